lif_neuron: RTL and testbench
=============================

Name: lif_neuron

Overview:
Single leaky integrate-and-fire neuron in the standard 8-in / 8-out / 8-bidir tile wrapper.
- Two 3-bit weighted input channels are integrated into a 7-bit membrane potential each enabled cycle.
- The neuron leaks, fires a one-cycle spike at threshold, resets, then stays refractory.
- Neuron parameters are loaded through a serial shift interface on the bidirectional pins.

Parameters:
PARAM_BITS, 24, length of serial parameter word.
DEF_THRESHOLD, 64, reset-default firing threshold.
DEF_LEAK, 1, reset-default leak per cycle.
DEF_WEIGHT_A, 2, reset-default channel A weight.
DEF_WEIGHT_B, 2, reset-default channel B weight.
DEF_REFRACT, 2, reset-default refractory length in cycles.

Ports:
clk  in  1  single clock, all state on rising edge.
rst_n  in  1  reset, synchronous and active-high (asserted = 1) despite the name.
ena  in  1  update enable; 0 freezes neuron and loader state.
ui_in  in  8  [2:0] channel A count, [5:3] channel B count, [7:6] unused.
uo_out  out  8  [6:0] membrane potential V_mem, [7] spike.
uio_in  in  8  [0] load_mode, [1] serial_data, others ignored.
uio_out  out  8  [2] params_ready, [3] spike_monitor, all other bits 0.
uio_oe  out  8  constant 8'b1111_1100 (bits 0-1 inputs, 2-7 outputs).

Behaviour:
Reset:
- V_mem=0, spike=0, refractory counter=0, spike_monitor=0.
- params_ready=0, shift register and bit counter=0.
- Parameters take DEF_* values.

Parameter word, MSB first:
- [23:16] threshold (8b, unsigned).
- [15:12] leak.
- [11:8] weight_a.
- [7:4] weight_b.
- [3:0] refractory.

Loader (active when ena=1):
- On each cycle with load_mode=1: shift serial_data in at the LSB and increment the bit counter.
- When a shift makes the counter reach 24: commit the word to the active parameters atomically on that edge, set params_ready=1, clear the counter.
- Further bits start a new word.
- params_ready clears on the first shift of a new word.
- load_mode=0: counter is held, no partial commit.

Neuron (ena=1):
- I = A*weight_a + B*weight_b, unsigned, 8b, max 210.
- Compute in 10 bits: t = V + I - leak. Clamp to [0,127] to give v_next.
- If refractory counter > 0: decrement it, V stays 0, spike=0, inputs and leak ignored.
- Else if v_next >= threshold: spike=1 for exactly that registered cycle, V=0, counter=refractory.
- Else: V=v_next, spike=0.
- threshold > 127 never fires.
- threshold 0 fires on every non-refractory cycle.
- Latency: outputs are registered and reflect inputs sampled one edge earlier.
- spike_monitor toggles on every spike.
- Loading proceeds concurrently with integration. Integration uses the old parameters until commit; a commit edge uses the old parameters for that cycle's update.
- ena=0: all registers hold, outputs stable.
- Reset overrides everything, including mid-load and mid-refractory.

Decomposition:
- Package lif_pkg: field widths, field bit positions, DEF_* constants, uio_oe constant.
- Sub-module lif_param_loader: shift register, counter, commit, params_ready.
- Integrate/fire/refractory logic stays in the top.

Test Plan:
- Reset then idle (ui_in=0): V_mem=0, spike=0, uio_oe=0xFC, params_ready=0.
- Defaults, A=3, B=0, ena=1: V rises 5/cycle (5,10,...,60); spike=1 on the 13th update with V_mem=0; spike_monitor=1.
- Refractory: after that spike, V_mem stays 0 for 2 cycles with A=3, then rises to 5.
- Leak: preload V=10 via A, then A=B=0: V decrements 1/cycle to 0 and saturates at 0, never negative.
- Serial load of 0x1E_0_5_0_3 (threshold=30, leak=0, wA=5, wB=0, refract=3) over 24 load_mode cycles: params_ready rises after the 24th bit. Then A=2 gives +10/cycle and spike at V≥30 (3rd update), followed by 3 refractory cycles.
- Clamp/freeze: threshold 200, A=B=7, weights 15: V saturates at 127, no spike. ena=0 mid-run holds V_mem; reset mid-load clears params_ready and restores defaults.

Source files
------------

// File: rtl/lif_pkg.sv
// Shared constants and parameter-word layout for the leaky integrate-and-fire neuron tile.
package lif_pkg;

    localparam int PARAM_BITS = 24;
    localparam int CNT_W      = 5;

    localparam int THR_W  = 8;
    localparam int LEAK_W = 4;
    localparam int WT_W   = 4;
    localparam int REF_W  = 4;

    localparam int THR_LSB  = 16;
    localparam int LEAK_LSB = 12;
    localparam int WA_LSB   = 8;
    localparam int WB_LSB   = 4;
    localparam int REF_LSB  = 0;

    localparam logic [THR_W-1:0]  DEF_THRESHOLD = 8'd64;
    localparam logic [LEAK_W-1:0] DEF_LEAK      = 4'd1;
    localparam logic [WT_W-1:0]   DEF_WEIGHT_A  = 4'd2;
    localparam logic [WT_W-1:0]   DEF_WEIGHT_B  = 4'd2;
    localparam logic [REF_W-1:0]  DEF_REFRACT   = 4'd2;

    localparam logic [7:0] UIO_OE = 8'b1111_1100;

    // Field order matches the serial word, so a shifted word casts straight into this struct.
    typedef struct packed {
        logic [THR_W-1:0]  threshold;
        logic [LEAK_W-1:0] leak;
        logic [WT_W-1:0]   weight_a;
        logic [WT_W-1:0]   weight_b;
        logic [REF_W-1:0]  refract;
    } params_t;

    localparam params_t DEF_PARAMS = '{
        threshold: DEF_THRESHOLD,
        leak:      DEF_LEAK,
        weight_a:  DEF_WEIGHT_A,
        weight_b:  DEF_WEIGHT_B,
        refract:   DEF_REFRACT
    };

endpackage

// File: rtl/lif_neuron_if.sv
// Tile pin bundle: enable, dedicated inputs/outputs and the bidirectional bank.
interface lif_neuron_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );

endinterface

// File: rtl/lif_param_loader.sv
// Serial MSB-first parameter loader; commits a full 24-bit word atomically to the active set.
module lif_param_loader
    import lif_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_ena,
    input  logic    i_load_mode,
    input  logic    i_serial_data,
    output params_t o_params,
    output logic    o_params_ready
);

    logic [PARAM_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_count;
    params_t               r_params;
    logic                  r_ready;
    logic [PARAM_BITS-1:0] w_next_shift;

    assign w_next_shift = {r_shift[PARAM_BITS-2:0], i_serial_data};

    // NOTE: rst_n is active-high and synchronous here; all state uses non-blocking
    // assignments so every register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_shift  <= '0;
            r_count  <= '0;
            r_params <= DEF_PARAMS;
            r_ready  <= 1'b0;
        end else if (i_ena && i_load_mode) begin
            r_shift <= w_next_shift;
            if (r_count == CNT_W'(PARAM_BITS - 1)) begin
                r_count  <= '0;
                r_params <= params_t'(w_next_shift);
                r_ready  <= 1'b1;
            end else begin
                r_count <= r_count + CNT_W'(1);
                if (r_count == '0) begin
                    r_ready <= 1'b0;
                end
            end
        end
    end

    assign o_params       = r_params;
    assign o_params_ready = r_ready;

endmodule

// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: two weighted channels, clamped 7-bit membrane, refractory hold.
module lif_neuron
    import lif_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    lif_neuron_if.slave  bus
);

    params_t            w_params;
    logic               w_params_ready;
    logic [2:0]         w_count_a;
    logic [2:0]         w_count_b;
    logic [7:0]         w_current;
    logic signed [9:0]  w_t;
    logic [6:0]         w_vnext;
    logic               w_fire;
    logic               w_unused;

    logic [6:0]         r_vmem;
    logic               r_spike;
    logic [REF_W-1:0]   r_refract;
    logic               r_spike_mon;

    lif_param_loader u_loader (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ena          (bus.ena),
        .i_load_mode    (bus.uio_in[0]),
        .i_serial_data  (bus.uio_in[1]),
        .o_params       (w_params),
        .o_params_ready (w_params_ready)
    );

    assign w_count_a = bus.ui_in[2:0];
    assign w_count_b = bus.ui_in[5:3];
    assign w_unused  = &{1'b0, bus.ui_in[7:6], bus.uio_in[7:2]};

    assign w_current = ({5'b0, w_count_a} * {4'b0, w_params.weight_a})
                     + ({5'b0, w_count_b} * {4'b0, w_params.weight_b});

    // Ten signed bits hold the full range 127 + 210 down to -15 without wrap.
    assign w_t = signed'({3'b000, r_vmem}) + signed'({2'b00, w_current})
               - signed'({6'b00_0000, w_params.leak});

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_vnext = w_t[6:0];
        if (w_t < 10'sd0) begin
            w_vnext = 7'd0;
        end else if (w_t > 10'sd127) begin
            w_vnext = 7'd127;
        end
    end

    assign w_fire = ({1'b0, w_vnext} >= w_params.threshold);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_vmem      <= '0;
            r_spike     <= 1'b0;
            r_refract   <= '0;
            r_spike_mon <= 1'b0;
        end else if (bus.ena) begin
            if (r_refract != '0) begin
                r_refract <= r_refract - REF_W'(1);
                r_vmem    <= '0;
                r_spike   <= 1'b0;
            end else if (w_fire) begin
                r_spike     <= 1'b1;
                r_vmem      <= '0;
                r_refract   <= w_params.refract;
                r_spike_mon <= ~r_spike_mon;
            end else begin
                r_vmem  <= w_vnext;
                r_spike <= 1'b0;
            end
        end
    end

    assign bus.uo_out  = {r_spike, r_vmem};
    assign bus.uio_out = {4'b0000, r_spike_mon, w_params_ready, 2'b00};
    assign bus.uio_oe  = UIO_OE;

endmodule

// File: tb/tb_lif_neuron.sv
// Directed self-checking bench for lif_neuron with hand-computed expected values.
module tb_lif_neuron;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    lif_neuron_if bus ();

    lif_neuron dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        bus.ena    = 1'b1;
        rst_n      = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_vec++;
        if (bus.uo_out !== 8'h00) begin
            n_err++; $display("FAIL reset_uo_out got %h want %h", bus.uo_out, 8'h00);
        end
        n_vec++;
        if (bus.uio_out !== 8'h00) begin
            n_err++; $display("FAIL reset_uio_out got %h want %h", bus.uio_out, 8'h00);
        end
        n_vec++;
        if (bus.uio_oe !== 8'hFC) begin
            n_err++; $display("FAIL reset_uio_oe got %h want %h", bus.uio_oe, 8'hFC);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
                n_err++;
                $display("FAIL idle_%0d got uo=%h uio=%h want uo=00 uio=00", k, bus.uo_out, bus.uio_out);
            end
        end
    endtask

    // Defaults: A=3 -> 3*2-1 = +5 per update, threshold 64 reached on update 13 (65).
    task automatic test_integrate_and_refractory();
        apply_reset();
        bus.ui_in = 8'h03;
        for (int k = 1; k <= 12; k++) begin
            tick();
            n_vec++;
            if (bus.uo_out !== 8'(5 * k)) begin
                n_err++; $display("FAIL integrate_%0d got %h want %h", k, bus.uo_out, 8'(5 * k));
            end
        end
        tick();
        n_vec++;
        if (bus.uo_out !== 8'h80) begin
            n_err++; $display("FAIL spike_uo_out got %h want %h", bus.uo_out, 8'h80);
        end
        n_vec++;
        if (bus.uio_out !== 8'h08) begin
            n_err++; $display("FAIL spike_monitor got %h want %h", bus.uio_out, 8'h08);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_vec++;
            if (bus.uo_out !== 8'h00) begin
                n_err++; $display("FAIL refract_%0d got %h want %h", k, bus.uo_out, 8'h00);
            end
        end
        tick();
        n_vec++;
        if (bus.uo_out !== 8'h05) begin
            n_err++; $display("FAIL post_refract got %h want %h", bus.uo_out, 8'h05);
        end
        n_vec++;
        if (bus.uio_out !== 8'h08) begin
            n_err++; $display("FAIL monitor_hold got %h want %h", bus.uio_out, 8'h08);
        end
    endtask

    task automatic test_leak();
        apply_reset();
        bus.ui_in = 8'h03;
        tick();
        tick();
        n_vec++;
        if (bus.uo_out !== 8'd10) begin
            n_err++; $display("FAIL leak_preload got %h want %h", bus.uo_out, 8'd10);
        end
        bus.ui_in = 8'h00;
        for (int k = 1; k <= 13; k++) begin
            tick();
            n_vec++;
            if (bus.uo_out !== ((k <= 10) ? 8'(10 - k) : 8'h00)) begin
                n_err++;
                $display("FAIL leak_%0d got %h want %h", k, bus.uo_out, (k <= 10) ? 8'(10 - k) : 8'h00);
            end
        end
    endtask

    // Word 0x1E0503: thr=30 leak=0 wA=5 wB=0 refract=3. The commit edge still uses defaults.
    task automatic test_serial_load();
        logic [23:0] word;
        word = 24'h1E0503;
        apply_reset();
        for (int i = 23; i >= 0; i--) begin
            bus.uio_in = {6'b0, word[i], 1'b1};
            bus.ui_in  = (i == 0) ? 8'h03 : 8'h00;
            tick();
            n_vec++;
            if (bus.uio_out[2] !== (i == 0)) begin
                n_err++;
                $display("FAIL load_ready_bit%0d got %b want %b", i, bus.uio_out[2], (i == 0));
            end
        end
        n_vec++;
        if (bus.uo_out !== 8'h05) begin
            n_err++; $display("FAIL commit_uses_old got %h want %h", bus.uo_out, 8'h05);
        end
        bus.uio_in = 8'h00;
        bus.ui_in  = 8'h02;
        tick();
        n_vec++;
        if (bus.uo_out !== 8'd15) begin
            n_err++; $display("FAIL new_params_1 got %h want %h", bus.uo_out, 8'd15);
        end
        tick();
        n_vec++;
        if (bus.uo_out !== 8'd25) begin
            n_err++; $display("FAIL new_params_2 got %h want %h", bus.uo_out, 8'd25);
        end
        tick();
        n_vec++;
        if (bus.uo_out !== 8'h80 || bus.uio_out !== 8'h0C) begin
            n_err++;
            $display("FAIL new_thr_spike got uo=%h uio=%h want uo=80 uio=0c", bus.uo_out, bus.uio_out);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (bus.uo_out !== 8'h00) begin
                n_err++; $display("FAIL new_refract_%0d got %h want %h", k, bus.uo_out, 8'h00);
            end
        end
        tick();
        n_vec++;
        if (bus.uo_out !== 8'd10) begin
            n_err++; $display("FAIL new_post_refract got %h want %h", bus.uo_out, 8'd10);
        end
    endtask

    // Continues from test_serial_load (V=10, ready=1, monitor=1); word 0xC80FF0: thr=200, w=15/15.
    task automatic test_clamp_freeze_reset();
        logic [23:0] word;
        word = 24'hC80FF0;
        bus.ui_in  = 8'h00;
        bus.uio_in = {6'b0, word[23], 1'b1};
        tick();
        n_vec++;
        if (bus.uio_out[2] !== 1'b0) begin
            n_err++; $display("FAIL ready_clear got %b want %b", bus.uio_out[2], 1'b0);
        end
        bus.uio_in = {6'b0, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) tick();
        for (int i = 22; i >= 0; i--) begin
            bus.uio_in = {6'b0, word[i], 1'b1};
            tick();
            n_vec++;
            if (bus.uio_out[2] !== (i == 0)) begin
                n_err++;
                $display("FAIL held_ready_bit%0d got %b want %b", i, bus.uio_out[2], (i == 0));
            end
        end
        bus.uio_in = 8'h00;
        bus.ui_in  = 8'h3F;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (bus.uo_out !== 8'h7F || bus.uio_out !== 8'h0C) begin
                n_err++;
                $display("FAIL clamp_%0d got uo=%h uio=%h want uo=7f uio=0c", k, bus.uo_out, bus.uio_out);
            end
        end
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h03;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_vec++;
            if (bus.uo_out !== 8'h7F || bus.uio_out !== 8'h0C) begin
                n_err++;
                $display("FAIL freeze_%0d got uo=%h uio=%h want uo=7f uio=0c", k, bus.uo_out, bus.uio_out);
            end
        end
        bus.ena = 1'b1;
        tick();
        n_vec++;
        if (bus.uio_out[2] !== 1'b0) begin
            n_err++; $display("FAIL midload_ready got %b want %b", bus.uio_out[2], 1'b0);
        end
        for (int k = 0; k < 4; k++) tick();
        rst_n = 1'b1;
        tick();
        rst_n      = 1'b0;
        bus.uio_in = 8'h00;
        n_vec++;
        if (bus.uo_out !== 8'h00 || bus.uio_out !== 8'h00) begin
            n_err++;
            $display("FAIL midload_reset got uo=%h uio=%h want uo=00 uio=00", bus.uo_out, bus.uio_out);
        end
        bus.ui_in = 8'h03;
        tick();
        n_vec++;
        if (bus.uo_out !== 8'h05) begin
            n_err++; $display("FAIL defaults_restored got %h want %h", bus.uo_out, 8'h05);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b1;
        bus.ena    = 1'b0;
        bus.ui_in  = 8'h00;
        bus.uio_in = 8'h00;
        test_reset();
        test_integrate_and_refractory();
        test_leak();
        test_serial_load();
        test_clamp_freeze_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
